traffic_phase_sequencer: RTL and testbench
==========================================

TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

Interface
REQ-001 The block SHALL have parameter MIN_DUR, default 8'd1: the substitute value for any duration input equal to 0.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock, rising edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tick_1s, input, 1 bit: a single-cycle pulse issued once per second.
REQ-005 The block SHALL have port sim_state, input, 2 bits: 0 = STOP, 1 = PLAY, 2 = PAUSE, 3 = reserved and treated as PAUSE.
REQ-006 The block SHALL have ports n_duration, s_duration, w_duration and e_duration, each input, 8 bits: green time in seconds for that direction.
REQ-007 The block SHALL have ports yellow_duration and red_holding, each input, 8 bits: yellow time and all-red clearance time in seconds.
REQ-008 The block SHALL have ports light_n, light_s, light_w and light_e, each output, 2 bits: 00 = red, 01 = yellow, 10 = green; the value 11 SHALL never be driven.
REQ-009 The block SHALL have port active_dir, output, 2 bits: the direction being served, with 0 = N, 1 = S, 2 = W, 3 = E.
REQ-010 The block SHALL have port phase, output, 2 bits: 0 = IDLE, 1 = GREEN, 2 = YELLOW, 3 = ALLRED.
REQ-011 The block SHALL have port remaining, output, 8 bits: seconds left in the current phase.
REQ-012 The block SHALL have port cycle_done, output, 1 bit: a one-cycle pulse marking the end of a full N-S-W-E cycle.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 Only the light of active_dir SHALL be non-red: green in GREEN, yellow in YELLOW; all lights SHALL be red in IDLE and ALLRED.
REQ-015 From IDLE, the first clock edge with sim_state = PLAY SHALL enter GREEN with active_dir = N and remaining = the N duration.
REQ-016 A tick_1s arriving on that same edge SHALL be ignored.
REQ-017 In GREEN, YELLOW or ALLRED with PLAY, each tick_1s SHALL decrement remaining by 1, except as set out in REQ-018.
REQ-018 A tick_1s with remaining = 1 SHALL instead advance on that edge: GREEN to YELLOW loading yellow_duration; YELLOW to ALLRED loading red_holding; ALLRED to GREEN of the next direction loading that direction's duration.
REQ-019 Direction order SHALL be N, S, W, E, then back to N; active_dir SHALL wrap 3 to 0.
REQ-020 The ALLRED(E) to GREEN(N) transition SHALL assert cycle_done for exactly one cycle.
REQ-021 Each duration SHALL be sampled only at the moment its phase is loaded; changes during a phase SHALL take effect at the next load of that phase.
REQ-022 Any duration input equal to 0 SHALL be loaded as MIN_DUR, so remaining is never 0 outside IDLE.
REQ-023 In PAUSE or reserved state, all state, remaining and lights SHALL hold and ticks SHALL be ignored.
REQ-024 On PAUSE to PLAY, the sequence SHALL resume with no reload.
REQ-025 On STOP in any phase, the next edge SHALL enter IDLE with all lights red, active_dir = 0, remaining = 0 and cycle_done = 0.
REQ-026 STOP SHALL take priority over a coincident tick.
REQ-027 Remaining SHALL never underflow; it SHALL decrement only while it is at least 2.
REQ-028 A tick_1s without PLAY SHALL be discarded, not queued.

Reset
REQ-029 While reset = 1, the block SHALL hold phase = IDLE, active_dir = 0, remaining = 0, cycle_done = 0 and all lights = 00, independent of clk.
REQ-030 After reset release, the block SHALL behave as IDLE and wait for PLAY.
REQ-031 A reset asserted mid-phase SHALL discard all progress.

Verification
REQ-032 Reset, then PLAY with n = 3, yellow = 2, red_holding = 1 and a tick every 4 cycles: expect light_n green with remaining 3, 2, 1, then yellow with 2, 1, then all red with 1, then light_s green.
REQ-033 Run all four directions with durations 2/2/2/2, yellow = 1 and red_holding = 1: expect exactly one cycle_done pulse, coincident with the entry to GREEN(N), after 16 ticks.
REQ-034 PAUSE at remaining = 5 in GREEN(W), apply 10 ticks, then PLAY: expect remaining 5 held throughout, then counting resumes at 4.
REQ-035 STOP during YELLOW(S) on the same edge as a tick: expect IDLE, all lights red and remaining 0; the following PLAY starts GREEN(N).
REQ-036 Set s_duration = 0, then run: expect GREEN(S) to load remaining = 1 and last exactly one tick.
REQ-037 Change n_duration from 15 to 9 during GREEN(N): expect the current count to continue from 15, and the next GREEN(N) to load 9.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Four-way traffic light sequencer: N, S, W, E in turn, each GREEN -> YELLOW -> ALLRED,
// paced by a once-per-second tick and controlled by a STOP / PLAY / PAUSE mode input.
module traffic_phase_sequencer #(
  parameter logic [7:0] MIN_DUR = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic [1:0] sim_state,
  input  logic [7:0] n_duration,
  input  logic [7:0] s_duration,
  input  logic [7:0] w_duration,
  input  logic [7:0] e_duration,
  input  logic [7:0] yellow_duration,
  input  logic [7:0] red_holding,
  output logic [1:0] light_n,
  output logic [1:0] light_s,
  output logic [1:0] light_w,
  output logic [1:0] light_e,
  output logic [1:0] active_dir,
  output logic [1:0] phase,
  output logic [7:0] remaining,
  output logic       cycle_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } phase_t;

  localparam logic [1:0] SIM_STOP = 2'd0;
  localparam logic [1:0] SIM_PLAY = 2'd1;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  phase_t     r_phase;
  logic [1:0] r_dir;
  logic [7:0] r_rem;
  logic       r_cycle_done;
  logic [1:0] r_light_n;
  logic [1:0] r_light_s;
  logic [1:0] r_light_w;
  logic [1:0] r_light_e;

  phase_t     w_phase_nxt;
  logic [1:0] w_dir_nxt;
  logic [7:0] w_rem_nxt;
  logic       w_cycle_done_nxt;
  logic [1:0] w_dir_inc;
  logic [7:0] w_dir_inc_dur;
  logic       w_stop;
  logic       w_play;

  // A zero duration would leave a phase with nothing to count, so it is replaced by MIN_DUR.
  function automatic logic [7:0] fix_dur(input logic [7:0] d);
    return (d == 8'd0) ? MIN_DUR : d;
  endfunction

  function automatic logic [1:0] light_for(input phase_t ph, input logic [1:0] dir,
                                           input logic [1:0] me);
    logic [1:0] l;
    l = LIGHT_RED;
    if (dir == me) begin
      if (ph == ST_GREEN)  l = LIGHT_GREEN;
      if (ph == ST_YELLOW) l = LIGHT_YELLOW;
    end
    return l;
  endfunction

  assign w_stop    = (sim_state == SIM_STOP);
  assign w_play    = (sim_state == SIM_PLAY);
  assign w_dir_inc = r_dir + 2'd1;

  always_comb begin
    w_dir_inc_dur = n_duration;
    case (w_dir_inc)
      2'd0:    w_dir_inc_dur = n_duration;
      2'd1:    w_dir_inc_dur = s_duration;
      2'd2:    w_dir_inc_dur = w_duration;
      default: w_dir_inc_dur = e_duration;
    endcase
  end

  // Next-state logic; PAUSE and the reserved mode fall through the defaults and hold.
  always_comb begin
    w_phase_nxt      = r_phase;
    w_dir_nxt        = r_dir;
    w_rem_nxt        = r_rem;
    w_cycle_done_nxt = 1'b0;
    if (w_stop) begin
      w_phase_nxt = ST_IDLE;
      w_dir_nxt   = 2'd0;
      w_rem_nxt   = 8'd0;
    end else if (w_play) begin
      case (r_phase)
        ST_IDLE: begin
          w_phase_nxt = ST_GREEN;
          w_dir_nxt   = 2'd0;
          w_rem_nxt   = fix_dur(n_duration);
        end
        default: begin
          if (tick_1s) begin
            if (r_rem >= 8'd2) begin
              w_rem_nxt = r_rem - 8'd1;
            end else begin
              case (r_phase)
                ST_GREEN: begin
                  w_phase_nxt = ST_YELLOW;
                  w_rem_nxt   = fix_dur(yellow_duration);
                end
                ST_YELLOW: begin
                  w_phase_nxt = ST_ALLRED;
                  w_rem_nxt   = fix_dur(red_holding);
                end
                default: begin
                  w_phase_nxt      = ST_GREEN;
                  w_dir_nxt        = w_dir_inc;
                  w_rem_nxt        = fix_dur(w_dir_inc_dur);
                  w_cycle_done_nxt = (r_dir == 2'd3);
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase      <= ST_IDLE;
      r_dir        <= 2'd0;
      r_rem        <= 8'd0;
      r_cycle_done <= 1'b0;
      r_light_n    <= LIGHT_RED;
      r_light_s    <= LIGHT_RED;
      r_light_w    <= LIGHT_RED;
      r_light_e    <= LIGHT_RED;
    end else begin
      r_phase      <= w_phase_nxt;
      r_dir        <= w_dir_nxt;
      r_rem        <= w_rem_nxt;
      r_cycle_done <= w_cycle_done_nxt;
      r_light_n    <= light_for(w_phase_nxt, w_dir_nxt, 2'd0);
      r_light_s    <= light_for(w_phase_nxt, w_dir_nxt, 2'd1);
      r_light_w    <= light_for(w_phase_nxt, w_dir_nxt, 2'd2);
      r_light_e    <= light_for(w_phase_nxt, w_dir_nxt, 2'd3);
    end
  end

  assign light_n    = r_light_n;
  assign light_s    = r_light_s;
  assign light_w    = r_light_w;
  assign light_e    = r_light_e;
  assign active_dir = r_dir;
  assign phase      = r_phase;
  assign remaining  = r_rem;
  assign cycle_done = r_cycle_done;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: hand-computed phase, direction, countdown,
// light and cycle_done expectations for each scenario.
module tb_traffic_phase_sequencer;

  localparam logic [1:0] P_IDLE = 2'd0, P_GREEN = 2'd1, P_YELLOW = 2'd2, P_ALLRED = 2'd3;
  localparam logic [1:0] M_STOP = 2'd0, M_PLAY = 2'd1, M_PAUSE = 2'd2, M_RSVD = 2'd3;

  logic       clk;
  logic       reset;
  logic       tick_1s;
  logic [1:0] sim_state;
  logic [7:0] n_duration, s_duration, w_duration, e_duration;
  logic [7:0] yellow_duration, red_holding;
  logic [1:0] light_n, light_s, light_w, light_e;
  logic [1:0] active_dir;
  logic [1:0] phase;
  logic [7:0] remaining;
  logic       cycle_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cd_count = 0;

  traffic_phase_sequencer #(.MIN_DUR(8'd1)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .sim_state(sim_state),
    .n_duration(n_duration), .s_duration(s_duration),
    .w_duration(w_duration), .e_duration(e_duration),
    .yellow_duration(yellow_duration), .red_holding(red_holding),
    .light_n(light_n), .light_s(light_s), .light_w(light_w), .light_e(light_e),
    .active_dir(active_dir), .phase(phase), .remaining(remaining),
    .cycle_done(cycle_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [1:0] exp_light(input logic [1:0] ph, input logic [1:0] dir,
                                           input logic [1:0] me);
    if (dir != me) return 2'b00;
    if (ph == P_GREEN) return 2'b10;
    if (ph == P_YELLOW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk_out(input string tag, input logic [1:0] ph, input logic [1:0] dir,
                         input logic [7:0] rem);
    logic [7:0] lights;
    lights = {exp_light(ph, dir, 2'd0), exp_light(ph, dir, 2'd1),
              exp_light(ph, dir, 2'd2), exp_light(ph, dir, 2'd3)};
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".dir"}, 32'(active_dir), 32'(dir));
    chk({tag, ".rem"}, 32'(remaining), 32'(rem));
    chk({tag, ".lights"}, 32'({light_n, light_s, light_w, light_e}), 32'(lights));
  endtask

  // driver: one clock with tick_1s = t, sampled 1 ns after the edge
  task automatic cyc(input logic t);
    tick_1s = t;
    @(posedge clk);
    #1;
    tick_1s = 1'b0;
    if (cycle_done === 1'b1) cd_count++;
  endtask

  // one second: three quiet cycles followed by a tick cycle
  task automatic tick_sec();
    for (int i = 0; i < 3; i++) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic set_dur(input logic [7:0] n, input logic [7:0] s, input logic [7:0] w,
                         input logic [7:0] e, input logic [7:0] y, input logic [7:0] r);
    n_duration = n; s_duration = s; w_duration = w; e_duration = e;
    yellow_duration = y; red_holding = r;
  endtask

  task automatic restart();
    sim_state = M_STOP;
    cyc(1'b0);
    sim_state = M_PLAY;
    cyc(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    tick_1s = 1'b0;
    sim_state = M_STOP;
    set_dur(8'd3, 8'd4, 8'd5, 8'd6, 8'd2, 8'd1);
    #1;
    chk_out("reset_hold", P_IDLE, 2'd0, 8'd0);
    chk("reset_cd", 32'(cycle_done), 32'd0);
    #20;
    reset = 1'b0;
    cyc(1'b1);
    cyc(1'b0);
    chk_out("idle_after_reset", P_IDLE, 2'd0, 8'd0);

    // basic walk through N, play edge coincident with a tick that must be ignored
    sim_state = M_PLAY;
    cyc(1'b1);
    chk_out("basic_gn3", P_GREEN, 2'd0, 8'd3);
    tick_sec(); chk_out("basic_gn2", P_GREEN, 2'd0, 8'd2);
    tick_sec(); chk_out("basic_gn1", P_GREEN, 2'd0, 8'd1);
    tick_sec(); chk_out("basic_yn2", P_YELLOW, 2'd0, 8'd2);
    tick_sec(); chk_out("basic_yn1", P_YELLOW, 2'd0, 8'd1);
    tick_sec(); chk_out("basic_arn1", P_ALLRED, 2'd0, 8'd1);
    tick_sec(); chk_out("basic_gs4", P_GREEN, 2'd1, 8'd4);

    // full cycle: one cycle_done, landing on GREEN(N) after 16 ticks
    set_dur(8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1);
    restart();
    chk_out("cyc_start", P_GREEN, 2'd0, 8'd2);
    cd_count = 0;
    for (int i = 0; i < 15; i++) tick_sec();
    chk_out("cyc_t15", P_ALLRED, 2'd3, 8'd1);
    chk("cyc_cd_before", 32'(cd_count), 32'd0);
    tick_sec();
    chk("cyc_cd_pulse", 32'(cycle_done), 32'd1);
    chk_out("cyc_t16", P_GREEN, 2'd0, 8'd2);
    cyc(1'b0);
    chk("cyc_cd_one_cycle", 32'(cycle_done), 32'd0);
    chk("cyc_cd_count", 32'(cd_count), 32'd1);

    // pause at remaining 5 in GREEN(W)
    set_dur(8'd1, 8'd1, 8'd7, 8'd1, 8'd1, 8'd1);
    restart();
    for (int i = 0; i < 8; i++) tick_sec();
    chk_out("pause_pre", P_GREEN, 2'd2, 8'd5);
    for (int i = 0; i < 10; i++) begin
      sim_state = (i < 5) ? M_PAUSE : M_RSVD;
      tick_sec();
      chk_out("pause_hold", P_GREEN, 2'd2, 8'd5);
    end
    sim_state = M_PLAY;
    cyc(1'b0);
    chk_out("pause_resume", P_GREEN, 2'd2, 8'd5);
    tick_sec();
    chk_out("pause_count", P_GREEN, 2'd2, 8'd4);

    // STOP with a coincident tick during YELLOW(S)
    set_dur(8'd1, 8'd2, 8'd1, 8'd1, 8'd3, 8'd1);
    restart();
    for (int i = 0; i < 7; i++) tick_sec();
    chk_out("stop_pre", P_YELLOW, 2'd1, 8'd3);
    sim_state = M_STOP;
    cyc(1'b1);
    chk_out("stop_idle", P_IDLE, 2'd0, 8'd0);
    chk("stop_cd", 32'(cycle_done), 32'd0);
    cyc(1'b1);
    sim_state = M_PLAY;
    cyc(1'b0);
    chk_out("stop_replay", P_GREEN, 2'd0, 8'd1);

    // zero duration is loaded as MIN_DUR
    set_dur(8'd1, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1);
    restart();
    for (int i = 0; i < 3; i++) tick_sec();
    chk_out("zero_gs", P_GREEN, 2'd1, 8'd1);
    tick_sec();
    chk_out("zero_ys", P_YELLOW, 2'd1, 8'd1);

    // duration change mid-phase applies at the next load
    set_dur(8'd15, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    restart();
    chk_out("chg_gn15", P_GREEN, 2'd0, 8'd15);
    tick_sec();
    n_duration = 8'd9;
    tick_sec();
    chk_out("chg_gn13", P_GREEN, 2'd0, 8'd13);
    for (int i = 0; i < 24; i++) tick_sec();
    chk_out("chg_gn9", P_GREEN, 2'd0, 8'd9);
    chk("chg_cd", 32'(cycle_done), 32'd1);

    // asynchronous reset mid-phase, observed between clock edges
    tick_sec();
    #2;
    reset = 1'b1;
    #1;
    chk_out("areset_mid", P_IDLE, 2'd0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    sim_state = M_PLAY;
    cyc(1'b0);
    chk_out("areset_replay", P_GREEN, 2'd0, 8'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
